// File: rtl/mov_pkg.sv
// Shared types and constants for the MOV1/MOV2 register-move pair issuer.
package mov_pkg;

  localparam int unsigned REG_IDX_W = 3;

  localparam logic [3:0] MOV1_OPC  = 4'b1110;
  localparam logic [3:0] MOV2_OPC  = 4'b1111;
  localparam logic [7:0] NOP_INSTR = 8'h00;

  // A pending register-move request: copy src into dst.
  typedef struct packed {
    logic [REG_IDX_W-1:0] dst;
    logic [REG_IDX_W-1:0] src;
  } mov_req_t;

  typedef enum logic [1:0] {
    StIdle,
    StMov1,
    StMov2
  } mov_state_e;

  // Both pair bytes carry a register index in bits 3:1 with bit 0 held at zero.
  function automatic logic [7:0] mov_byte(input logic [3:0] opc,
                                          input logic [REG_IDX_W-1:0] idx);
    return {opc, idx, 1'b0};
  endfunction

endpackage

// File: rtl/mov_req_fifo.sv
// Synchronous request FIFO of mov_req_t with full/empty flags.
// Depth must be a power of two so the pointers wrap naturally.
import mov_pkg::*;

module mov_req_fifo #(
  parameter int unsigned Depth = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  mov_req_t wdata,
  output mov_req_t rdata,
  output logic     full,
  output logic     empty
);

  localparam int unsigned AW = $clog2(Depth);

  mov_req_t        mem_q [Depth];
  logic [AW-1:0]   wptr_q;
  logic [AW-1:0]   rptr_q;
  logic [AW:0]     count_q;
  logic            do_push;
  logic            do_pop;

  assign full    = (count_q == (AW+1)'(Depth));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q];

  // Pointer and occupancy update; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since the flags gate every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/mov_pair_issuer.sv
// Issues MOV1 (1110_ddd_0) then MOV2 (1111_sss_0) on consecutive cycles per request.
// Build option MOV_ISSUER_FIFO_EN: buffer requests in a FIFO_DEPTH-entry queue instead of
// a single holding register.
import mov_pkg::*;

module mov_pair_issuer #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enabled,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_dst,
  input  logic [2:0] req_src,
  output logic [7:0] instr_out,
  output logic       instr_valid,
  output logic       busy,
  output logic [7:0] pair_count
);

  if ((FIFO_DEPTH < 2) || (FIFO_DEPTH > 16) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0))
  begin : g_bad_depth
    $error("mov_pair_issuer: FIFO_DEPTH must be a power of two in 2..16");
  end

  mov_state_e     state_q;
  logic [2:0]     src_q;
  mov_req_t       in_req;
  mov_req_t       pend;
  logic           pend_valid;
  logic           accept;
  logic           launch;
  logic           self_move;

  assign in_req = '{dst: req_dst, src: req_src};
  assign accept = req_valid && req_ready;
  // MOV1 is never interruptible, so a new pair can only start from IDLE or MOV2.
  assign launch    = pend_valid && enabled && (state_q != StMov1);
  assign self_move = (pend.dst == pend.src);
  assign busy      = (state_q != StIdle) || pend_valid;

`ifdef MOV_ISSUER_FIFO_EN
  logic fifo_full;
  logic fifo_empty;

  mov_req_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (launch),
    .wdata (in_req),
    .rdata (pend),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign pend_valid = !fifo_empty;
  assign req_ready  = !fifo_full;
`else
  logic     hold_valid_q;
  mov_req_t hold_q;

  assign pend       = hold_q;
  assign pend_valid = hold_valid_q;
  assign req_ready  = !hold_valid_q;

  // Holding register: freed on the launch edge so the next request lands during MOV1.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
    end else if (launch) begin
      hold_valid_q <= 1'b0;
    end else if (accept) begin
      hold_valid_q <= 1'b1;
      hold_q       <= in_req;
    end
  end
`endif

  // Pair sequencer with registered byte, valid and completed-pair counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      src_q       <= '0;
      instr_out   <= NOP_INSTR;
      instr_valid <= 1'b0;
      pair_count  <= 8'd0;
    end else begin
      unique case (state_q)
        StIdle, StMov2: begin
          if (state_q == StMov2) pair_count <= pair_count + 8'd1;
          // Self-moves are popped by launch but emit nothing.
          if (launch && !self_move) begin
            state_q     <= StMov1;
            src_q       <= pend.src;
            instr_out   <= mov_byte(MOV1_OPC, pend.dst);
            instr_valid <= 1'b1;
          end else begin
            state_q     <= StIdle;
            instr_out   <= NOP_INSTR;
            instr_valid <= 1'b0;
          end
        end
        StMov1: begin
          state_q     <= StMov2;
          instr_out   <= mov_byte(MOV2_OPC, src_q);
          instr_valid <= 1'b1;
        end
        default: begin
          state_q     <= StIdle;
          instr_out   <= NOP_INSTR;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
